barrel_shift_pipe: RTL and testbench
====================================

BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width; power of two, 2..64.
REQ-002 SHALL have localparam SHW = log2(WIDTH), giving the shift-amount width and the stage count.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in, input, WIDTH: operand.
REQ-006 SHALL have port shamt, input, SHW: shift amount, 0..WIDTH-1.
REQ-007 SHALL have port mode, input, 2: operation code. 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-008 SHALL have port in_valid, input, 1: operand, shamt and mode are valid.
REQ-009 SHALL have port in_ready, output, 1: block can accept an operand.
REQ-010 SHALL have port out, output, WIDTH: result.
REQ-011 SHALL have port out_valid, output, 1: out is valid.
REQ-012 SHALL have port out_ready, input, 1: sink accepts out.

Function
REQ-013 SHALL implement SHW registered stages; stage k conditionally shifts by 2^k when shamt[k] is set.
REQ-014 SHALL carry mode, the residual shamt bits and a valid bit through each stage.
REQ-015 SHALL define advance = !out_valid || out_ready.
  - When advance is 1, every stage shifts forward one position.
  - When advance is 0, every stage holds its contents.
REQ-016 SHALL drive in_ready = advance combinationally.
REQ-017 SHALL accept a transfer on a rising edge where in_valid && in_ready.
REQ-018 SHALL load a bubble (valid=0) into stage 0 when advance=1 and in_valid=0.
  - Bubbles are not collapsed.
REQ-019 SHALL have a latency of exactly SHW cycles from the accepting edge to out_valid high, with no stall.
  - Throughput is one result per cycle.
REQ-020 SHALL hold out and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL define LSL as: result = in << shamt, zero fill.
REQ-022 SHALL define LSR as: result = in >> shamt, zero fill.
REQ-023 SHALL define ASR as: result = in >> shamt, filled with in[WIDTH-1].
REQ-024 SHALL define ROR as: rotate right by shamt, per REQ-031.
REQ-025 SHALL pass in through unchanged for shamt=0 in every mode.
REQ-026 SHALL accept a new operand on the same edge that out is consumed, when out_valid && out_ready && in_valid.
  - No bubble is inserted in this case.
REQ-027 SHALL compute out purely from registered stage state, with no combinational path from in to out.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear every stage valid bit, out_valid, and all stage data, so out=0.
REQ-029 SHALL discard all in-flight operands when reset is asserted mid-operation.
  - The first accept after reset release starts a clean pipeline.
REQ-030 SHALL drive in_ready to 1 during and immediately after reset, because out_valid=0.

Configuration
REQ-031 SHALL use macro BARREL_ROTATE_EN to compile rotate in or out.
  - Defined: mode 11 performs rotate right.
  - Undefined: mode 11 is decoded at stage 0 as LSR, and no rotate logic is synthesised.

Structure
REQ-032 SHALL place the mode codes (MODE_LSL, MODE_LSR, MODE_ASR, MODE_ROR) and a stage-record typedef (data, mode, shamt, valid) in shared package barrel_pkg.
REQ-033 SHALL implement each stage as one instance of sub-module barrel_stage.
  - barrel_stage parameters: WIDTH and stage index K.
  - barrel_stage contains a combinational shift by 2^K plus its register with enable.
  - barrel_stage is generated SHW times.

Verification
REQ-034 SHALL verify a logical right shift (WIDTH=8): in=8'h80, shamt=4, mode=LSR -> out=8'h08, out_valid high 3 cycles after accept.
REQ-035 SHALL verify an arithmetic right shift: in=8'h80, shamt=2, mode=ASR -> out=8'hE0; and in=8'h40, shamt=2, ASR -> 8'h10.
REQ-036 SHALL verify a left shift and a zero shift: in=8'hFF, shamt=7, mode=LSL -> out=8'h80; in=8'hA5, shamt=0, any mode -> out=8'hA5.
REQ-037 SHALL verify rotate and its compile-out: in=8'h81, shamt=1, mode=ROR -> 8'hC0 with BARREL_ROTATE_EN, 8'h40 without.
REQ-038 SHALL verify backpressure with a stream of 6 back-to-back operands and out_ready held low for 5 cycles after the first out_valid.
  - Required: in_ready low while stalled, out stable, all 6 results delivered in order with none lost or duplicated.
REQ-039 SHALL verify reset mid-operation: with 3 operands in flight, pulse rst_n low for 1 cycle -> out_valid=0 and out=0 immediately, none of those 3 results ever appears, and a subsequent operand returns after 3 cycles.

Source files
------------

// File: rtl/barrel_pkg.sv
// barrel_pkg
// Shared definitions for the pipelined barrel shifter.
//   MODE_LSL / MODE_LSR / MODE_ASR / MODE_ROR : operation codes carried on 'mode'
//   stage_t                                   : record held in every pipeline stage
// stage_t is sized for the largest supported WIDTH (64) so that one typedef serves
// every instantiation; a narrower shifter leaves the upper data bits at zero.
package barrel_pkg;

    localparam int MAX_W   = 64;
    localparam int MAX_SHW = 6;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef struct packed {
        logic [MAX_W-1:0]   data;
        logic [1:0]         mode;
        logic [MAX_SHW-1:0] shamt;
        logic               valid;
    } stage_t;

endpackage

// File: rtl/barrel_stage.sv
// barrel_stage
// One pipeline stage of the barrel shifter: shifts the incoming record by 2^K when
// shamt bit K is set, then registers the whole record when 'en' is high.
// Optional feature: define BARREL_ROTATE_EN to include the rotate-right path.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears the stage register
//   en    : pipeline advance; the register holds when low
//   d     : record from the previous stage (or the input decode)
//   q     : registered record for the next stage
module barrel_stage
    import barrel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  stage_t d,
    output stage_t q
);

    localparam int S = 1 << K;

    logic        [WIDTH-1:0] din;
    logic signed [WIDTH-1:0] din_s;
    logic        [WIDTH-1:0] shifted;
    stage_t                  nxt;
    logic                    unused_hi;

    assign din       = d.data[WIDTH-1:0];
    assign din_s     = $signed(din);
    // Upper record bits beyond WIDTH are always zero and never looked at.
    assign unused_hi = ^(d.data >> WIDTH);

    always_comb begin
        shifted = din;
        if (d.shamt[K]) begin
            case (d.mode)
                MODE_LSL: shifted = din << S;
                MODE_ASR: shifted = din_s >>> S;
`ifdef BARREL_ROTATE_EN
                MODE_ROR: shifted = (din >> S) | (din << (WIDTH - S));
`endif
                default:  shifted = din >> S;
            endcase
        end
    end

    always_comb begin
        nxt      = d;
        nxt.data = MAX_W'(shifted);
    end

    // ---- stage K register boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe
// Pipelined barrel shifter with valid/ready handshake on both sides. SHW = log2(WIDTH)
// registered stages, stage k shifting by 2^k; the whole pipe advances or holds as one.
// Optional feature: define BARREL_ROTATE_EN to enable rotate-right (mode 11);
// without it mode 11 is decoded to a logical right shift on entry.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset, flushes the pipe
//   in        : operand
//   shamt     : shift amount, 0..WIDTH-1
//   mode      : 00 LSL, 01 LSR, 10 ASR, 11 ROR
//   in_valid  : in/shamt/mode valid
//   in_ready  : pipe accepts an operand this cycle
//   out       : result, straight from the last stage register
//   out_valid : out holds a result
//   out_ready : sink takes out this cycle
module barrel_shift_pipe
    import barrel_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready
);

    logic       advance;
    logic [1:0] mode_dec;
    stage_t     stage_in;
    stage_t     stage_q [0:SHW-1];
    logic       unused_tail;

    // A full pipe still moves when the sink drains the last stage, so a new
    // operand can enter on the same edge the result leaves.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

`ifdef BARREL_ROTATE_EN
    assign mode_dec = mode;
`else
    assign mode_dec = (mode == MODE_ROR) ? MODE_LSR : mode;
`endif

    // An idle input cycle enters as an all-zero bubble.
    always_comb begin
        stage_in = '0;
        if (in_valid) begin
            stage_in.data  = MAX_W'(in);
            stage_in.mode  = mode_dec;
            stage_in.shamt = MAX_SHW'(shamt);
            stage_in.valid = 1'b1;
        end
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        stage_t d_k;
        if (k == 0) begin : g_first
            assign d_k = stage_in;
        end else begin : g_rest
            assign d_k = stage_q[k-1];
        end

        // ---- stage k: shift by 2^k, registered ----
        barrel_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (advance),
            .d     (d_k),
            .q     (stage_q[k])
        );
    end

    assign out       = stage_q[SHW-1].data[WIDTH-1:0];
    assign out_valid = stage_q[SHW-1].valid;

    // Mode and residual shift amount are spent once the last stage is reached.
    assign unused_tail = ^{stage_q[SHW-1].mode, stage_q[SHW-1].shamt,
                           stage_q[SHW-1].data >> WIDTH};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
module tb_barrel_shift_pipe;

    localparam int W   = 8;
    localparam int SHW = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in_d;
    logic [2:0]   shamt;
    logic [1:0]   mode;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_d;
    logic         out_valid;
    logic         out_ready;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;
    logic [W-1:0] expq [$];
    bit           hold_chk = 0;

    barrel_shift_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_d),
        .shamt     (shamt),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out_d),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the shift rules written as plain integer arithmetic.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] x, input int sh,
                                               input logic [1:0] md);
        longint unsigned v, mask, r;
        v    = x;
        mask = (64'd1 << W) - 1;
        case (md)
            2'b00: r = (v << sh) & mask;
            2'b01: r = v >> sh;
            2'b10: begin
                r = v >> sh;
                if (x[W-1]) r = r | (~(mask >> sh) & mask);
            end
            default: begin
`ifdef BARREL_ROTATE_EN
                r = ((v >> sh) | (v << (W - sh))) & mask;
`else
                r = v >> sh;
`endif
            end
        endcase
        return r[W-1:0];
    endfunction

    // Called just after a falling edge: drives inputs, then checks the handshake
    // and the scoreboard for the coming rising edge.
    task automatic drive_check(input bit iv, input logic [W-1:0] x, input logic [2:0] sh,
                               input logic [1:0] md, input bit ordy, output bit acc);
        in_valid  = iv;
        in_d      = x;
        shamt     = sh;
        mode      = md;
        out_ready = ordy;
        #1;
        if (hold_chk) begin
            chk("hold_vld", out_valid, 1);
            if (expq.size() != 0) chk("hold_out", out_d, expq[0]);
        end
        chk("in_ready", in_ready, !out_valid || out_ready);
        hold_chk = out_valid && !out_ready;
        if (out_valid && out_ready) begin
            if (expq.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
                chk("data", out_d, expq.pop_front());
                n_pop++;
            end
        end
        acc = in_valid && in_ready;
        if (acc) expq.push_back(ref_shift(x, sh, md));
    endtask

    task automatic cycle(input bit iv, input logic [W-1:0] x, input logic [2:0] sh,
                         input logic [1:0] md, input bit ordy, output bit acc);
        @(negedge clk);
        drive_check(iv, x, sh, md, ordy, acc);
    endtask

    // One operand into an empty pipe; checks acceptance, latency and the value.
    task automatic single(input logic [W-1:0] x, input logic [2:0] sh, input logic [1:0] md,
                          input logic [W-1:0] exp, input string tag);
        bit a;
        int lat;
        cycle(1, x, sh, md, 1, a);
        chk({tag, "_acc"}, a, 1);
        lat = 0;
        do begin
            cycle(0, '0, '0, '0, 1, a);
            lat++;
        end while (!out_valid && lat < 20);
        chk({tag, "_lat"}, lat, SHW);
        chk({tag, "_out"}, out_d, exp);
    endtask

    initial begin
        bit a;
        logic [W-1:0] ops_x  [6];
        logic [2:0]   ops_sh [6];
        logic [1:0]   ops_md [6];
        int j, guard, stall, pop0;
        bit first, ordy;

        rst_n = 1'b0; in_d = '0; shamt = '0; mode = '0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out_d, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed values
        single(8'h80, 3'd4, 2'b01, 8'h08, "lsr_80_4");
        single(8'h80, 3'd2, 2'b10, 8'hE0, "asr_80_2");
        single(8'h40, 3'd2, 2'b10, 8'h10, "asr_40_2");
        single(8'hFF, 3'd7, 2'b00, 8'h80, "lsl_ff_7");
        for (int m = 0; m < 4; m++) single(8'hA5, 3'd0, 2'(m), 8'hA5, "zero_shift");
`ifdef BARREL_ROTATE_EN
        single(8'h81, 3'd1, 2'b11, 8'hC0, "ror_81_1");
`else
        single(8'h81, 3'd1, 2'b11, 8'h40, "ror_off_81_1");
`endif
        single(8'h96, 3'd7, 2'b10, 8'hFF, "asr_96_7");

        // Six back-to-back operands, sink stalls 5 cycles after the first result
        for (int i = 0; i < 6; i++) begin
            ops_x[i]  = 8'($urandom);
            ops_sh[i] = 3'($urandom_range(0, 7));
            ops_md[i] = 2'($urandom_range(0, 3));
        end
        j = 0; guard = 0; stall = 0; first = 0; pop0 = n_pop;
        while ((j < 6 || expq.size() != 0) && guard < 60) begin
            @(negedge clk);
            if (out_valid) first = 1;
            ordy = !(first && stall < 5);
            if (!ordy) stall++;
            if (j < 6) drive_check(1, ops_x[j], ops_sh[j], ops_md[j], ordy, a);
            else       drive_check(0, '0, '0, '0, ordy, a);
            if (!ordy) chk("stall_in_ready", in_ready, 0);
            if (a) j++;
            guard++;
        end
        chk("stream_delivered", n_pop - pop0, 6);
        chk("stream_stalls", stall, 5);

        // Reset with three operands in flight
        for (int i = 0; i < 3; i++) begin
            cycle(1, 8'($urandom), 3'($urandom_range(1, 7)), 2'($urandom_range(0, 3)), 1, a);
            chk("pre_rst_acc", a, 1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out", out_d, 0);
        chk("midrst_in_ready", in_ready, 1);
        expq.delete();
        hold_chk = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("postrst_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            cycle(0, '0, '0, '0, 1, a);
            chk("flushed", out_valid, 0);
        end
        single(8'h3C, 3'd2, 2'b00, 8'hF0, "after_rst");

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7, 8'($urandom), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), $urandom_range(0, 9) < 6, a);
        end
        guard = 0;
        while (expq.size() != 0 && guard < 30) begin
            cycle(0, '0, '0, '0, 1, a);
            guard++;
        end
        chk("drain_empty", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
